// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase accumulator DDS with glitch-free tune/wave switching.
// Define DDS_SINE_LUT_EN for a quarter-wave sine ROM on wave 3 (else constant 512).
module dds_phase_gen #(
  parameter int PHASE_W = 24
) (
  input  logic               Fg_CLK,
  input  logic               Fg_RESETn,
  input  logic               DDSEnable,
  input  logic               DDSReady,
  input  logic [PHASE_W-1:0] TuneWord,
  input  logic               TuneLoad,
  input  logic [1:0]         WaveSel,
  output logic [9:0]         SampleData,
  output logic               SampleValid,
  output logic               PhaseWrap,
  output logic               TunePending
);
  logic [PHASE_W-1:0] phase_q, phase_d, act_q, act_d, ptune_q, ptune_d;
  logic [PHASE_W:0]   sum;
  logic               pend_q, pend_d, acc_q, acc_d, carry_q, carry_d, accept;
  logic [1:0]         wave_req_q, wave_req_d, wave_act_q, wave_act_d;
  logic [9:0]         sample_q, sample_d, wave_val, tri_u;
  logic               valid_q, valid_d, wrap_q, wrap_d;
`ifdef DDS_SINE_LUT_EN
  localparam logic [8:0] SINE_ROM [64] = '{
    9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
    9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
    9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
    9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
    9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
    9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
    9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
    9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
  };
  logic [5:0] sin_idx;
  logic [8:0] sin_q;
  logic [9:0] sine_val;
  always_comb begin
    sin_idx  = phase_q[PHASE_W-3 -: 6] ^ {6{phase_q[PHASE_W-2]}};
    sin_q    = SINE_ROM[sin_idx];
    sine_val = phase_q[PHASE_W-1] ? 10'd511 - {1'b0, sin_q} : 10'd512 + {1'b0, sin_q};
  end
`else
  logic [9:0] sine_val;
  assign sine_val = 10'd512;
`endif
  always_comb begin
    accept     = DDSEnable & DDSReady;
    sum        = {1'b0, phase_q} + {1'b0, act_q};
    phase_d    = !DDSReady ? '0 : accept ? sum[PHASE_W-1:0] : phase_q;
    carry_d    = accept & sum[PHASE_W];
    acc_d      = accept;
    act_d      = (accept & pend_q) ? ptune_q : act_q;
    ptune_d    = TuneLoad ? TuneWord : ptune_q;
    pend_d     = TuneLoad | (pend_q & ~accept);
    wave_req_d = WaveSel;
    wave_act_d = (!DDSReady || carry_d) ? wave_req_q : wave_act_q;
    // Output stage maps the phase produced by the previous accepted strobe.
    tri_u      = phase_q[PHASE_W-2 -: 10];
    wave_val   = wave_act_q == 2'd0 ? phase_q[PHASE_W-1 -: 10] :
                 wave_act_q == 2'd1 ? {10{phase_q[PHASE_W-1]}} :
                 wave_act_q == 2'd2 ? (phase_q[PHASE_W-1] ? ~tri_u : tri_u) : sine_val;
    valid_d    = acc_q & DDSReady;
    wrap_d     = valid_d & carry_q;
    sample_d   = valid_d ? wave_val : sample_q;
  end
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      phase_q    <= '0;
      act_q      <= '0;
      ptune_q    <= '0;
      pend_q     <= 1'b0;
      acc_q      <= 1'b0;
      carry_q    <= 1'b0;
      wave_req_q <= 2'd0;
      wave_act_q <= 2'd0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      act_q      <= act_d;
      ptune_q    <= ptune_d;
      pend_q     <= pend_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      wave_req_q <= wave_req_d;
      wave_act_q <= wave_act_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end
  assign SampleData  = sample_q;
  assign SampleValid = valid_q;
  assign PhaseWrap   = wrap_q;
  assign TunePending = pend_q;
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed + random stimulus against an arithmetic DDS reference model.
module tb_dds_phase_gen;
  localparam int W = 24;
  localparam longint unsigned MOD = 64'd1 << W;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b0, tl = 1'b0;
  logic [W-1:0] tw = '0;
  logic [1:0] ws = 2'd0;
  logic [9:0] sd;
  logic sv, pw, tp;
  int n_chk = 0, n_fail = 0;
  longint unsigned m_phase = 0, m_act = 0, m_ptune = 0;
  bit m_pend = 0;
  int m_wave = 0;
  logic [9:0] last_sd = '0;
  always #5 clk = ~clk;
  dds_phase_gen #(.PHASE_W(W)) dut (
    .Fg_CLK(clk), .Fg_RESETn(rst_n), .DDSEnable(en), .DDSReady(rdy),
    .TuneWord(tw), .TuneLoad(tl), .WaveSel(ws),
    .SampleData(sd), .SampleValid(sv), .PhaseWrap(pw), .TunePending(tp)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] wave_of(input longint unsigned p, input int w);
    longint unsigned u, msb;
    int i, q;
    msb = (p >> (W - 1)) & 1;
    u = (p >> (W - 11)) & 1023;
    i = 0;
    q = 0;
    case (w)
      0: return 10'(p >> (W - 10));
      1: return msb != 0 ? 10'd1023 : 10'd0;
      2: return msb != 0 ? 10'(1023 - u) : 10'(u);
      default: begin
`ifdef DDS_SINE_LUT_EN
        i = int'((p >> (W - 8)) & 63);
        if (((p >> (W - 2)) & 1) != 0) i = 63 - i;
        q = $rtoi(511.0 * $sin(3.14159265358979 * (i + 0.5) / 128.0) + 0.5);
        return msb != 0 ? 10'(511 - q) : 10'(512 + q);
`else
        return 10'd512 + 10'(i + q);
`endif
      end
    endcase
  endfunction
  function automatic bit model_strobe(input bit load, input logic [W-1:0] w);
    longint unsigned s;
    s = m_phase + m_act;
    m_phase = s % MOD;
    if (m_pend) begin m_act = m_ptune; m_pend = 0; end
    if (load) begin m_ptune = w; m_pend = 1; end
    if (s >= MOD) m_wave = ws;
    return s >= MOD;
  endfunction
  task automatic strobe(input bit load, input logic [W-1:0] w);
    bit carry;
    @(posedge clk); #1 en = 1; tl = load; tw = w;
    carry = model_strobe(load, w);
    @(posedge clk); #1 en = 0; tl = 0;
    chk("pending", tp, m_pend);
    chk("valid_early", sv, 0);
    @(posedge clk); #1
    last_sd = wave_of(m_phase, m_wave);
    chk("valid", sv, 1);
    chk("data", sd, last_sd);
    chk("wrap", pw, carry);
    @(posedge clk); #1 chk("valid_pulse", sv, 0);
  endtask
  task automatic load(input logic [W-1:0] w);
    @(posedge clk); #1 tl = 1; tw = w;
    m_ptune = w; m_pend = 1;
    @(posedge clk); #1 tl = 0;
    chk("pend_set", tp, 1);
  endtask
  task automatic go_idle();
    @(posedge clk); #1 rdy = 0;
    repeat (2) @(posedge clk);
    #1 m_phase = 0; m_wave = ws;
    chk("idle_valid", sv, 0);
    chk("idle_hold", sd, last_sd);
  endtask
  task automatic go_run();
    @(posedge clk); #1 rdy = 1;
  endtask
  task automatic set_wave(input logic [1:0] w);
    @(posedge clk); #1 ws = w;
    repeat (2) @(posedge clk);
    #1 if (!rdy) m_wave = w;
  endtask
  initial begin
    #1000000 $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bit carry;
    repeat (3) @(posedge clk);
    #1 chk("rst_data", sd, 0);
    chk("rst_valid", sv, 0);
    chk("rst_wrap", pw, 0);
    chk("rst_pend", tp, 0);
    rst_n = 1; rdy = 1;
    load(24'h100000);
    repeat (18) strobe(0, '0);
    for (int k = 1; k <= 2; k++) begin
      go_idle();
      set_wave(2'(k));
      go_run();
      repeat (18) strobe(0, '0);
    end
    go_idle();
    set_wave(2'd0);
    go_run();
    repeat (5) strobe(0, '0);
    set_wave(2'd1);
    repeat (14) strobe(0, '0);
    load(W'($urandom));
    strobe(1, W'($urandom));
    chk("coincide_pend", tp, 1);
    strobe(0, '0);
    chk("promote_clear", tp, 0);
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) set_wave(2'($urandom_range(0, 3)));
      else if (r == 2) load(W'($urandom));
      else strobe(r == 3, W'($urandom));
    end
    go_idle();
    repeat (2) begin
      @(posedge clk); #1 en = 1;
      @(posedge clk); #1 en = 0;
      repeat (2) begin
        @(posedge clk); #1 chk("idle_strobe_valid", sv, 0);
        chk("idle_strobe_hold", sd, last_sd);
      end
    end
    go_run();
    repeat (3) strobe(0, '0);
    @(posedge clk); #1 en = 1;
    carry = model_strobe(0, '0);
    @(posedge clk); #1 en = 0; rdy = 0;
    @(posedge clk); #1 chk("inflight_valid", sv, 0);
    chk("inflight_wrap", pw, 0);
    chk("inflight_hold", sd, last_sd);
    m_phase = 0; m_wave = ws;
    go_run();
    repeat (2) strobe(0, '0);
    load(24'h345678);
    @(posedge clk); #1 en = 1;
    @(posedge clk); #1 en = 0;
    @(posedge clk); #3 rst_n = 0;
    #1 chk("arst_data", sd, 0);
    chk("arst_valid", sv, 0);
    chk("arst_wrap", pw, 0);
    chk("arst_pend", tp, 0);
    m_phase = 0; m_act = 0; m_ptune = 0; m_pend = 0; m_wave = 0; last_sd = '0;
    rdy = 0;
    @(negedge clk) rst_n = 1;
    set_wave(2'd3);
    go_run();
    load(24'h040000);
    repeat (70) strobe(0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
